// File: rtl/serial_sub_if.sv
// Valid/ready operand and result bundle for serial_sub.
// The master drives operands and result acceptance; the slave is the subtractor.
interface serial_sub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;
    logic             ovf;

    modport master (
        output in_valid, x, y, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero, ovf
    );

    modport slave (
        input  in_valid, x, y, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero, ovf
    );
endinterface

// File: rtl/serial_sub.sv
// Digit-serial subtractor: x - y - bin over WIDTH bits, DIGIT bits per clock, LSB first,
// with borrow-out, zero and signed-overflow flags and valid/ready handshakes on both sides.
module serial_sub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input logic         clk,
    input logic         rst_n,
    serial_sub_if.slave bus
);
    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d, zero_q, zero_d, ovf_q, ovf_d;

    logic [31:0]      idx;
    logic [DIGIT-1:0] x_dig, y_dig;
    logic [DIGIT:0]   dsub;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        x_d      = x_q;
        y_d      = y_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;

        idx   = 32'(cnt_q) * DIGIT;
        x_dig = x_q[idx +: DIGIT];
        y_dig = y_q[idx +: DIGIT];
        // Extra top bit of the digit difference is the digit's borrow-out.
        dsub  = {1'b0, x_dig} - {1'b0, y_dig} - {{DIGIT{1'b0}}, borrow_q};

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    x_d      = bus.x;
                    y_d      = bus.y;
                    borrow_d = bus.bin;
                    diff_d   = '0;
                    bout_d   = 1'b0;
                    zero_d   = 1'b0;
                    ovf_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = StRun;
                end
            end
            StRun: begin
                diff_d[idx +: DIGIT] = dsub[DIGIT-1:0];
                borrow_d             = dsub[DIGIT];
                cnt_d                = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    bout_d  = dsub[DIGIT];
                    zero_d  = (diff_d == '0);
                    ovf_d   = (x_q[WIDTH-1] != y_q[WIDTH-1]) && (diff_d[WIDTH-1] != x_q[WIDTH-1]);
                    cnt_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            x_q      <= x_d;
            y_q      <= y_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        bus.in_ready  = (state_q == StIdle);
        bus.out_valid = (state_q == StDone);
        bus.diff      = diff_q;
        bus.bout      = bout_q;
        bus.zero      = zero_q;
        bus.ovf       = ovf_q;
    end
endmodule
